// File: rtl/voice_sched_pkg.sv
// Shared types and constants for the voice scheduler: FSM states, the silence
// midpoint and a compile-time log2 used to size the accumulator and voice index.
package voice_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT_DONE,
    S_SETTLE,
    S_ACCUM,
    S_OUTPUT
  } vs_state_t;

  localparam logic [7:0] SILENCE = 8'h80;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_sched_timer.sv
// Down-counter shared by the timeout and settle phases; expired is high while
// the count sits at zero, so a load of N gives N+1 cycles before expiry.
module voice_sched_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/voice_scheduler.sv
// Walks the voices once per sample tick through a shared divider/waveshaper
// datapath and emits the averaged mix of the captured per-voice samples.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES     = 4,
  parameter int TIMEOUT_CYCLES = 63,
  parameter int SETTLE_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [NUM_VOICES-1:0]    voice_en,
  input  logic [16*NUM_VOICES-1:0] voice_divider,
  input  logic [16*NUM_VOICES-1:0] voice_count,
  input  logic [2*NUM_VOICES-1:0]  voice_mode,
  input  logic                     err_clr,
  output logic                     shp_sample_now,
  output logic [15:0]              shp_divider,
  output logic [15:0]              shp_count,
  output logic [1:0]               shp_mode,
  input  logic                     shp_done,
  input  logic [7:0]               shp_sample,
  output logic [7:0]               mix_out,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int IDX_W = clog2(NUM_VOICES);
  localparam int ACC_W = 8 + IDX_W;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam bit CAPTURE_ON_DONE = (SETTLE_CYCLES == 0);

  vs_state_t        state, state_next;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;

  logic             acc_clr, acc_add, snap, idx_clr, idx_inc, mix_load, to_set;
  logic [7:0]       add_val;
  logic             tmr_load, tmr_tick, tmr_expired;
  logic [CNT_W-1:0] tmr_val;

  // Truncating average: drop the log2(NUM_VOICES) fractional bits.
  function automatic logic [7:0] mix_scale(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] s;
    s = a >> IDX_W;
    return s[7:0];
  endfunction

  voice_sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    add_val    = SILENCE;
    snap       = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    mix_load   = 1'b0;
    to_set     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_tick   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_tick) begin
          acc_clr    = 1'b1;
          idx_clr    = 1'b1;
          state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (voice_en[idx]) begin
          snap       = 1'b1;
          state_next = S_LAUNCH;
        end else begin
          acc_add    = 1'b1;
          state_next = S_ACCUM;
        end
      end
      S_LAUNCH: begin
        tmr_load   = 1'b1;
        tmr_val    = TO_LOAD;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Completion is checked before expiry so a done on the last cycle wins.
        if (shp_done) begin
          if (CAPTURE_ON_DONE) begin
            acc_add    = 1'b1;
            add_val    = shp_sample;
            state_next = S_ACCUM;
          end else begin
            tmr_load   = 1'b1;
            tmr_val    = ST_LOAD;
            state_next = S_SETTLE;
          end
        end else if (tmr_expired) begin
          to_set     = 1'b1;
          acc_add    = 1'b1;
          state_next = S_ACCUM;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr_expired) begin
          acc_add    = 1'b1;
          add_val    = shp_sample;
          state_next = S_ACCUM;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      S_ACCUM: begin
        if (idx == IDX_W'(NUM_VOICES - 1)) begin
          mix_load   = 1'b1;
          state_next = S_OUTPUT;
        end else begin
          idx_inc    = 1'b1;
          state_next = S_SELECT;
        end
      end
      S_OUTPUT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Voice index, accumulator and operand snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      acc         <= '0;
      shp_divider <= '0;
      shp_count   <= '0;
      shp_mode    <= '0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (acc_clr)      acc <= '0;
      else if (acc_add) acc <= acc + {{IDX_W{1'b0}}, add_val};
      if (snap) begin
        shp_divider <= voice_divider[16*idx +: 16];
        shp_count   <= voice_count[16*idx +: 16];
        shp_mode    <= voice_mode[2*idx +: 2];
      end
    end
  end

  // Mix output and sticky flags; mix_out is loaded so it is valid with mix_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_out     <= SILENCE;
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mix_valid <= mix_load;
      if (mix_load) mix_out <= mix_scale(acc);
      if (sample_tick && (state != S_IDLE)) overrun <= 1'b1;
      else if (err_clr)                     overrun <= 1'b0;
      if (to_set)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  assign shp_sample_now = (state == S_LAUNCH);
  assign busy           = (state != S_IDLE);

endmodule
